// File: rtl/l1_pool_streamer_pkg.sv
// l1_pool_streamer shared definitions.
// Select codes, map geometry and the streamer FSM state encoding.
package l1_pool_streamer_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 12;
  localparam int MAP0_DIM = 64;
  localparam int MAP1_DIM = 32;
  localparam int IDX_W    = 10;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0   = 3'b001;
  localparam logic [2:0] SEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/l1_pool_streamer_skid_fifo.sv
// l1_skid_fifo: small synchronous FIFO holding prefetched words.
// DEPTH must be a power of two; push and pop may share a cycle.
module l1_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 30,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  // storage write; contents need no reset, occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/l1_pool_streamer.sv
// l1_pool_streamer: streams the pooled layer-1 map to the host.
// Define L1_GMAX_EN to add running-maximum outputs gmax/gmax_idx.
module l1_pool_streamer #(
  parameter int         DATA_W     = 20,
  parameter int         ADDR_W     = 12,
  parameter int         N_WORDS    = 1024,
  parameter logic [2:0] L1_SEL     = 3'b011,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [9:0]        out_index,
  output logic              out_last
`ifdef L1_GMAX_EN
  ,
  output logic [DATA_W-1:0] gmax,
  output logic [9:0]        gmax_idx
`endif
);
  import l1_pool_streamer_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = IDX_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] fl_idx;
  logic             inflight;
  logic [CW-1:0]    count;
  logic [FW-1:0]    head;
  logic [CW:0]      occ;
  logic             pop;
  logic             issue;
  logic             accept;
  logic [IDX_W-1:0] head_idx;

  assign head_idx = head[FW-1:DATA_W];
  assign accept   = (state == IDLE) && start;
  assign pop      = out_valid && out_ready;
  // occupancy after this cycle's pop, including the read in flight
  assign occ      = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue    = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue && rd_ptr == LAST_IDX) state_nx = DRAIN;
      DRAIN:   if (pop && head_idx == LAST_IDX) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // read pointer and single-cycle read latency tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      fl_idx   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fl_idx <= rd_ptr;
      if (accept)     rd_ptr <= '0;
      else if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  l1_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   ({fl_idx, cdata_rd}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign crd       = issue;
  assign caddr_rd  = ADDR_W'(rd_ptr);
  assign csel      = busy ? L1_SEL : SEL_NONE;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_index = out_valid ? head_idx : '0;
  assign out_last  = out_valid && (head_idx == LAST_IDX);

`ifdef L1_GMAX_EN
  // running maximum over handshaked words; ties keep the earlier index
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      gmax     <= '0;
      gmax_idx <= '0;
    end else if (pop && out_data > gmax) begin
      gmax     <= out_data;
      gmax_idx <= out_index;
    end
  end
`endif

endmodule

// File: tb/tb_l1_pool_streamer.sv
// Testbench for l1_pool_streamer: randomized back-pressure,
// queue scoreboard against a whole-map reference model.
module tb_l1_pool_streamer;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [9:0]  out_index;
  logic        out_last;
`ifdef L1_GMAX_EN
  logic [19:0] gmax;
  logic [9:0]  gmax_idx;
`endif

  typedef struct packed {
    logic [9:0]  idx;
    logic [19:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] mem [N];
  int          tests = 0;
  int          fails = 0;
  int          issued = 0;
  int          popped = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  bit          stalled = 0;
  logic [19:0] pd;
  logic [9:0]  pi;

  always #5 clk = ~clk;

  l1_pool_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .csel      (csel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
`ifdef L1_GMAX_EN
    ,
    .gmax      (gmax),
    .gmax_idx  (gmax_idx)
`endif
  );

  function automatic void chk(string name, longint got, longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endfunction

  // layer memory: one-cycle read latency, garbage when not read
  always @(posedge clk)
    cdata_rd <= crd ? mem[caddr_rd[9:0]] : 20'($urandom);

  // consumer ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 3);
      default: out_ready = 1'b0;
    endcase
  end

  // monitor: scoreboard pop, stall hold, outstanding reads, done count
  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk("stall_hold", {out_valid, out_index, out_data},
            {1'b1, pi, pd});
      stalled = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", out_index, 10'h3ff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word", {out_last, out_index, out_data},
              {(e.idx == 10'd1023), e.idx, e.data});
        end
      end
      if (crd || (out_valid && out_ready)) begin
        issued += int'(crd);
        popped += int'(out_valid && out_ready);
        chk("outstanding_gt2", longint'(issued - popped > 2), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic load_expect();
    for (int i = 0; i < N; i++)
      sb.push_back({10'(i), mem[i]});
    done_cnt = 0;
  endtask

  task automatic run_pass(input bit timed, input int mid_idx,
                          input int stall_cyc);
    int cyc = 0;
    int stall_left = stall_cyc;
    int crd_n = 0;
    bit seen = 0;
    bit kicked = 0;
    logic [19:0] m = '0;
    logic [9:0]  mi = '0;
    for (int i = 0; i < N; i++)
      if (mem[i] > m) begin
        m  = mem[i];
        mi = 10'(i);
      end
    load_expect();
    if (stall_cyc > 0) ready_mode = 2;
    pulse_start();
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stall_cyc > 0 && stall_left > 0) begin
        crd_n += int'(crd);
        if (out_valid) begin
          stall_left--;
          if (stall_left == 0) begin
            chk("stall_crd_gt2", longint'(crd_n > 2), 0);
            ready_mode = 0;
          end
        end
      end
      if (timed && cyc == 1)
        chk("first_read", {crd, caddr_rd}, {1'b1, 12'd0});
      if (timed && !done)
        chk("busy_csel", {busy, csel}, {1'b1, 3'b011});
      if (done) begin
        seen = 1;
        if (timed) begin
          chk("done_cycle", cyc, 1027);
          chk("done_busy_csel", {busy, csel}, {1'b0, 3'b000});
        end
`ifdef L1_GMAX_EN
        chk("gmax_at_done", {gmax_idx, gmax}, {mi, m});
`endif
      end
      if (mid_idx >= 0 && !kicked && out_valid &&
          out_index == 10'(mid_idx)) begin
        kicked = 1;
        pulse_start();
      end
    end
    chk("done_seen", seen, 1);
    repeat (5) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after", {busy, csel, out_valid}, 5'd0);
`ifdef L1_GMAX_EN
    chk("gmax_hold", {gmax_idx, gmax}, {mi, m});
`endif
  endtask

  task automatic reset_mid(input int at_idx);
    int cyc = 0;
    bit hit = 0;
    load_expect();
    ready_mode = 1;
    pulse_start();
    while (!hit && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      hit = out_valid && out_index == 10'(at_idx);
    end
    chk("reach_reset_idx", hit, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {busy, done, crd, caddr_rd, csel, out_valid,
         out_data, out_index, out_last}, 50'd0);
    sb.delete();
    issued = 0;
    popped = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", {done_cnt[3:0], busy}, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 20'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {busy, done, crd, caddr_rd, csel, out_valid,
         out_data, out_index, out_last}, 50'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    ready_mode = 0;
    run_pass(1, -1, 0);

    ready_mode = 1;
    run_pass(0, -1, 0);

    run_pass(0, -1, 50);

    ready_mode = 0;
    run_pass(0, 500, 0);

    reset_mid(300);
    ready_mode = 0;
    run_pass(1, -1, 0);

    for (int i = 0; i < N; i++) mem[i] = 20'($urandom) & 20'h7ffff;
    ready_mode = 1;
    run_pass(0, -1, 0);

`ifdef L1_GMAX_EN
    for (int i = 0; i < N; i++) mem[i] = 20'(i);
    mem[777] = 20'h0ffff;
    mem[900] = 20'h0ffff;
    ready_mode = 1;
    run_pass(0, -1, 0);
    chk("gmax_spec", {gmax_idx, gmax}, {10'd777, 20'h0ffff});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
